// File: rtl/ddsm_pkg.sv
// Shared types and constants for the MASH-1-1-1 stream decoder.
// The code span offsets describe the -3..+4 shaping range around the integer word.
package ddsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int INT_W        = 4;
    localparam int FRAC_W       = 16;
    localparam int DDSM_MIN_OFS = -3;
    localparam int DDSM_MAX_OFS = 4;

    function automatic logic [INT_W-1:0] code_min(input logic [INT_W-1:0] a,
                                                  input logic [INT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [INT_W-1:0] code_max(input logic [INT_W-1:0] a,
                                                  input logic [INT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddsm_avg_decoder_if.sv
// Sample input, control and result handshake bundle of the averaging decoder.
interface ddsm_avg_decoder_if #(
    parameter int FRAC_W = ddsm_pkg::FRAC_W
);
    logic                          start;
    logic                          abort;
    logic [ddsm_pkg::INT_W-1:0]    din;
    logic                          din_vld;
    logic                          busy;
    logic                          res_vld;
    logic                          res_rdy;
    logic [ddsm_pkg::INT_W-1:0]    res_int;
    logic [FRAC_W-1:0]             res_frac;
    logic [ddsm_pkg::INT_W-1:0]    res_min;
    logic [ddsm_pkg::INT_W-1:0]    res_max;

    modport master (
        output start, abort, din, din_vld, res_rdy,
        input  busy, res_vld, res_int, res_frac, res_min, res_max
    );

    modport slave (
        input  start, abort, din, din_vld, res_rdy,
        output busy, res_vld, res_int, res_frac, res_min, res_max
    );
endinterface

// File: rtl/ddsm_win_accum.sv
// Window datapath: running sum plus min/max of the stream codes.
// The *_next outputs already include the sample accepted this cycle.
module ddsm_win_accum
    import ddsm_pkg::*;
#(
    parameter int LOG2_WIN = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [INT_W-1:0]          din,
    output logic [INT_W+LOG2_WIN-1:0] sum_next,
    output logic [INT_W-1:0]          min_next,
    output logic [INT_W-1:0]          max_next
);
    localparam int SUM_W = INT_W + LOG2_WIN;

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [INT_W-1:0] min_q, min_d;
    logic [INT_W-1:0] max_q, max_d;

    // The sum is wide enough for a full window of 4'hF codes, so it never wraps.
    always_comb begin
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        if (clr) begin
            sum_d = '0;
            min_d = {INT_W{1'b1}};
            max_d = '0;
        end else if (en) begin
            sum_d = sum_q + SUM_W'(din);
            min_d = code_min(min_q, din);
            max_d = code_max(max_q, din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign sum_next = sum_d;
    assign min_next = min_d;
    assign max_next = max_d;
endmodule

// File: rtl/ddsm_avg_decoder.sv
// Boxcar-averages 2^LOG2_WIN DDSM codes to recover the {int,frac} division word.
// FSM, settle/window counters and result handshake live here; the sum is in ddsm_win_accum.
module ddsm_avg_decoder
    import ddsm_pkg::*;
#(
    parameter int LOG2_WIN = 16,
    parameter int SETTLE   = 4,
    parameter int FRAC_W   = ddsm_pkg::FRAC_W
)(
    input  logic               clk,
    input  logic               rst,
    ddsm_avg_decoder_if.slave  bus
);
    localparam int CNT_W = LOG2_WIN + 1;
    localparam int SUM_W = INT_W + LOG2_WIN;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << LOG2_WIN) - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t            state_q, state_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              busy_q, busy_d;
    logic              res_vld_q, res_vld_d;
    logic [INT_W-1:0]  res_int_q, res_int_d;
    logic [FRAC_W-1:0] res_frac_q, res_frac_d;
    logic [INT_W-1:0]  res_min_q, res_min_d;
    logic [INT_W-1:0]  res_max_q, res_max_d;

    logic              acc_clr, acc_en;
    logic [SUM_W-1:0]  acc_sum_next;
    logic [INT_W-1:0]  acc_min_next, acc_max_next;

    ddsm_win_accum #(.LOG2_WIN(LOG2_WIN)) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .en       (acc_en),
        .din      (bus.din),
        .sum_next (acc_sum_next),
        .min_next (acc_min_next),
        .max_next (acc_max_next)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        res_vld_d    = res_vld_q;
        res_int_d    = res_int_q;
        res_frac_d   = res_frac_q;
        res_min_d    = res_min_q;
        res_max_d    = res_max_q;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;

        // abort overrides everything, including a start or a final sample in the same cycle
        if (bus.abort) begin
            state_d   = ST_IDLE;
            res_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        settle_cnt_d = '0;
                        win_cnt_d    = '0;
                        if (SETTLE == 0) begin
                            state_d = ST_ACCUM;
                            acc_clr = 1'b1;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (bus.din_vld) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_d   = ST_ACCUM;
                            acc_clr   = 1'b1;
                            win_cnt_d = '0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (bus.din_vld) begin
                        acc_en = 1'b1;
                        if (win_cnt_q == WIN_LAST) begin
                            state_d    = ST_HOLD;
                            res_vld_d  = 1'b1;
                            res_int_d  = acc_sum_next[LOG2_WIN+INT_W-1:LOG2_WIN];
                            res_frac_d = FRAC_W'(acc_sum_next[LOG2_WIN-1:0]) << (FRAC_W - LOG2_WIN);
                            res_min_d  = acc_min_next;
                            res_max_d  = acc_max_next;
                        end else begin
                            win_cnt_d = win_cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.res_rdy) begin
                        state_d   = ST_IDLE;
                        res_vld_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            busy_q       <= 1'b0;
            res_vld_q    <= 1'b0;
            res_int_q    <= '0;
            res_frac_q   <= '0;
            res_min_q    <= '0;
            res_max_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            busy_q       <= busy_d;
            res_vld_q    <= res_vld_d;
            res_int_q    <= res_int_d;
            res_frac_q   <= res_frac_d;
            res_min_q    <= res_min_d;
            res_max_q    <= res_max_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.res_vld  = res_vld_q;
    assign bus.res_int  = res_int_q;
    assign bus.res_frac = res_frac_q;
    assign bus.res_min  = res_min_q;
    assign bus.res_max  = res_max_q;
endmodule

// File: tb/tb_ddsm_avg_decoder.sv
// Directed bench: a 256-sample decoder fed by a MASH-1-1-1 model, plus a 16-sample,
// zero-settle decoder for the half-LSB pattern and the abort/start collision.
module tb_ddsm_avg_decoder;
    import ddsm_pkg::*;

    localparam int LOG2_A   = 8;
    localparam int SETTLE_A = 4;
    localparam int LOG2_B   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddsm_avg_decoder_if #(.FRAC_W(16)) bus_a ();
    ddsm_avg_decoder_if #(.FRAC_W(16)) bus_b ();

    ddsm_avg_decoder #(.LOG2_WIN(LOG2_A), .SETTLE(SETTLE_A), .FRAC_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    ddsm_avg_decoder #(.LOG2_WIN(LOG2_B), .SETTLE(0), .FRAC_W(16)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // MASH-1-1-1 reference modulator, in_i=5, in_f=16'h4000
    logic [15:0] m_a1, m_a2, m_a3;
    int          m_c2d, m_c3d, m_c3dd;

    task automatic mod_reset();
        m_a1 = '0; m_a2 = '0; m_a3 = '0;
        m_c2d = 0; m_c3d = 0; m_c3dd = 0;
    endtask

    task automatic mod_step(output logic [3:0] y);
        logic [16:0] s1, s2, s3;
        int c1, c2, c3, yi;
        s1 = {1'b0, m_a1} + 17'h04000;
        s2 = {1'b0, m_a2} + {1'b0, s1[15:0]};
        s3 = {1'b0, m_a3} + {1'b0, s2[15:0]};
        c1 = int'(s1[16]); c2 = int'(s2[16]); c3 = int'(s3[16]);
        yi = 5 + c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
        m_a1 = s1[15:0]; m_a2 = s2[15:0]; m_a3 = s3[15:0];
        m_c2d = c2; m_c3dd = m_c3d; m_c3d = c3;
        y = 4'(yi);
    endtask

    logic [11:0] exp_sum;
    logic [3:0]  exp_min, exp_max;

    // mode 0: constant 7, mode 1: modulator; gap=1 drives din_vld on every other cycle
    task automatic run_a(input int mode, input bit gap, output int busy_cnt, output bit done);
        int acc_idx;
        bit vld;
        logic [3:0] y;
        exp_sum = '0; exp_min = 4'hF; exp_max = 4'h0;
        busy_cnt = 0; done = 1'b0; acc_idx = 0; y = 4'd0;
        mod_reset();
        @(negedge clk); bus_a.start = 1'b1; bus_a.din_vld = 1'b0;
        @(negedge clk); bus_a.start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_a.res_vld) begin done = 1'b1; break; end
            if (bus_a.busy) busy_cnt++;
            vld = !gap || (k % 2 == 0);
            if (vld) begin
                if (mode == 1) mod_step(y); else y = 4'd7;
                acc_idx++;
                if (acc_idx > SETTLE_A) begin
                    exp_sum = exp_sum + 12'(y);
                    if (y < exp_min) exp_min = y;
                    if (y > exp_max) exp_max = y;
                end
            end
            bus_a.din     = y;
            bus_a.din_vld = vld;
        end
        bus_a.din_vld = 1'b0;
        $display("run mode=%0d gap=%0d: int=%0d frac=0x%04h min=%0d max=%0d busy=%0d",
                 mode, gap, bus_a.res_int, bus_a.res_frac, bus_a.res_min, bus_a.res_max, busy_cnt);
    endtask

    task automatic check_res_a(input string pfx);
        check({pfx, "_vld"},  32'(bus_a.res_vld),  32'd1);
        check({pfx, "_busy"}, 32'(bus_a.busy),     32'd0);
        check({pfx, "_int"},  32'(bus_a.res_int),  32'(exp_sum[11:8]));
        check({pfx, "_frac"}, 32'(bus_a.res_frac), 32'({exp_sum[7:0], 8'h00}));
        check({pfx, "_min"},  32'(bus_a.res_min),  32'(exp_min));
        check({pfx, "_max"},  32'(bus_a.res_max),  32'(exp_max));
    endtask

    task automatic accept_a(input string pfx);
        @(negedge clk); bus_a.res_rdy = 1'b1;
        @(negedge clk); bus_a.res_rdy = 1'b0;
        check({pfx, "_acc_vld"},  32'(bus_a.res_vld), 32'd0);
        check({pfx, "_acc_busy"}, 32'(bus_a.busy),    32'd0);
    endtask

    initial begin
        int  busy_cnt;
        bit  done;
        int  diff;
        logic [19:0] word;

        bus_a.start = 0; bus_a.abort = 0; bus_a.din = 0; bus_a.din_vld = 0; bus_a.res_rdy = 0;
        bus_b.start = 0; bus_b.abort = 0; bus_b.din = 0; bus_b.din_vld = 0; bus_b.res_rdy = 0;

        repeat (2) @(negedge clk);
        check("rst_busy",  32'(bus_a.busy),     32'd0);
        check("rst_vld",   32'(bus_a.res_vld),  32'd0);
        check("rst_int",   32'(bus_a.res_int),  32'd0);
        check("rst_frac",  32'(bus_a.res_frac), 32'd0);
        check("rst_b_busy", 32'(bus_b.busy),    32'd0);
        rst = 1'b0;

        // constant 7
        run_a(0, 1'b0, busy_cnt, done);
        check("c1_done", 32'(done), 32'd1);
        check_res_a("c1");
        check("c1_int_const",  32'(bus_a.res_int), 32'd7);
        check("c1_busy_cycles", 32'(busy_cnt), 32'(SETTLE_A + (1 << LOG2_A)));
        accept_a("c1");

        // modulator stream, continuous
        run_a(1, 1'b0, busy_cnt, done);
        check("c2_done", 32'(done), 32'd1);
        check_res_a("c2");
        word = {bus_a.res_int, bus_a.res_frac};
        diff = int'(word) - 32'h54000;
        if (diff < 0) diff = -diff;
        check("c2_bound", 32'(diff <= (3 << (16 - LOG2_A))), 32'd1);
        check("c2_min_span", 32'(int'(bus_a.res_min) >= 5 + DDSM_MIN_OFS), 32'd1);
        check("c2_max_span", 32'(int'(bus_a.res_max) <= 5 + DDSM_MAX_OFS), 32'd1);
        check("c2_busy_cycles", 32'(busy_cnt), 32'(SETTLE_A + (1 << LOG2_A)));
        accept_a("c2");

        // modulator stream with 50% din_vld gaps
        run_a(1, 1'b1, busy_cnt, done);
        check("c3_done", 32'(done), 32'd1);
        check_res_a("c3");
        check("c3_busy_cycles", 32'(busy_cnt), 32'(2 * (SETTLE_A + (1 << LOG2_A)) - 1));

        // backpressure: result held, start ignored
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus_a.start = (k % 3 == 0);
            check("c4_hold_vld",  32'(bus_a.res_vld),  32'd1);
            check("c4_hold_frac", 32'(bus_a.res_frac), 32'({exp_sum[7:0], 8'h00}));
            check("c4_hold_busy", 32'(bus_a.busy),     32'd0);
        end
        @(negedge clk); bus_a.start = 1'b0;
        check("c4_still_int", 32'(bus_a.res_int), 32'(exp_sum[11:8]));
        accept_a("c4");
        // start honoured right after the handshake, then aborted out of SETTLE
        bus_a.start = 1'b1;
        @(negedge clk); bus_a.start = 1'b0;
        check("c4_restart_busy", 32'(bus_a.busy), 32'd1);
        bus_a.abort = 1'b1;
        @(negedge clk); bus_a.abort = 1'b0;
        check("c4_abort_busy", 32'(bus_a.busy),    32'd0);
        check("c4_abort_vld",  32'(bus_a.res_vld), 32'd0);
        $display("c4 backpressure/restart/abort sequence done");

        // asynchronous reset mid-ACCUM
        @(negedge clk); bus_a.start = 1'b1;
        @(negedge clk); bus_a.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bus_a.din = 4'd7; bus_a.din_vld = 1'b1;
            @(negedge clk);
        end
        check("c5_pre_busy", 32'(bus_a.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("c5_rst_busy", 32'(bus_a.busy),     32'd0);
        check("c5_rst_vld",  32'(bus_a.res_vld),  32'd0);
        check("c5_rst_int",  32'(bus_a.res_int),  32'd0);
        check("c5_rst_frac", 32'(bus_a.res_frac), 32'd0);
        check("c5_rst_min",  32'(bus_a.res_min),  32'd0);
        check("c5_rst_max",  32'(bus_a.res_max),  32'd0);
        @(negedge clk); rst = 1'b0; bus_a.din_vld = 1'b0;
        run_a(0, 1'b0, busy_cnt, done);
        check("c5_done", 32'(done), 32'd1);
        check_res_a("c5");
        accept_a("c5");

        // 16-sample window, no settle, alternating 3/4
        @(negedge clk); bus_b.start = 1'b1;
        @(negedge clk); bus_b.start = 1'b0;
        check("c6_busy_now", 32'(bus_b.busy), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_b.res_vld) begin done = 1'b1; break; end
            bus_b.din = (k % 2 == 0) ? 4'd3 : 4'd4;
            bus_b.din_vld = 1'b1;
        end
        bus_b.din_vld = 1'b0;
        $display("c6 result: int=%0d frac=0x%04h min=%0d max=%0d",
                 bus_b.res_int, bus_b.res_frac, bus_b.res_min, bus_b.res_max);
        check("c6_done", 32'(done), 32'd1);
        check("c6_int",  32'(bus_b.res_int),  32'd3);
        check("c6_frac", 32'(bus_b.res_frac), 32'h8000);
        check("c6_min",  32'(bus_b.res_min),  32'd3);
        check("c6_max",  32'(bus_b.res_max),  32'd4);
        @(negedge clk); bus_b.res_rdy = 1'b1;
        @(negedge clk); bus_b.res_rdy = 1'b0;
        check("c6_acc_vld", 32'(bus_b.res_vld), 32'd0);
        // abort and start together: stays idle
        bus_b.start = 1'b1; bus_b.abort = 1'b1;
        @(negedge clk); bus_b.start = 1'b0; bus_b.abort = 1'b0;
        check("c6_abort_start_busy", 32'(bus_b.busy), 32'd0);
        @(negedge clk);
        check("c6_abort_start_busy2", 32'(bus_b.busy),    32'd0);
        check("c6_abort_start_vld",   32'(bus_b.res_vld), 32'd0);
        $display("c6 abort+start collision done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
